// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential double-dabble binary-to-BCD converter with valid/ready handshakes
module bcd_seq_converter #(
    parameter int W      = 19,
    parameter int DIGITS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndig,
    output logic                         busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   adj;
    logic [NW-1:0]   ndig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-digit add-3 correction; each digit wraps within its own nibble.
    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] > 4'd4) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = acc_q[4*k +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = in_bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                busy    = 1'b1;
                acc_d   = {adj[BW-2:0], shift_q[W-1]};
                shift_d = {shift_q[W-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Significant-digit count from the registered accumulator, never below 1.
    always_comb begin
        ndig = NW'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] != 4'd0) begin
                ndig = NW'(k + 1);
            end
        end
    end

    assign out_bcd  = acc_q;
    assign out_ndig = ndig;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - self-checking bench for bcd_seq_converter
module tb_bcd_seq_converter;

    localparam int W  = 19;
    localparam int D  = 6;
    localparam int BW = 4 * D;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_bin;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_bcd;
    logic [NW-1:0] out_ndig;
    logic          busy;

    int errors = 0;
    int checks = 0;

    bcd_seq_converter #(.W(W), .DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bcd  (out_bcd),
        .out_ndig (out_ndig),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  bin;
        logic [BW-1:0] bcd;
        logic [NW-1:0] ndig;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal reference by repeated division.
    function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ref_ndig(input int unsigned v);
        int n;
        n = 1;
        v = v / 10;
        while (v > 0) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

    // One full transaction; noisy keeps in_valid high with changing in_bin while busy.
    task automatic run_one(input logic [W-1:0] v, input logic [BW-1:0] exp_bcd,
                           input int exp_nd, input bit noisy, input string tag);
        int lat;
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_bin   = v;
        tick();
        in_valid = noisy;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (noisy) in_bin = W'($urandom);
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, W + 1);
        check({tag, " bcd"}, out_bcd, exp_bcd);
        check({tag, " ndig"}, out_ndig, exp_nd);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, out_valid, 0);
        check({tag, " back in idle"}, in_ready, 1);
    endtask

    initial begin
        int got;
        int cyc;
        int unsigned exp_q[$];
        int unsigned e;

        vecs[0]  = '{19'd0,      24'h000000, 3'd1};
        vecs[1]  = '{19'd524287, 24'h524287, 3'd6};
        vecs[2]  = '{19'd1,      24'h000001, 3'd1};
        vecs[3]  = '{19'd9,      24'h000009, 3'd1};
        vecs[4]  = '{19'd10,     24'h000010, 3'd2};
        vecs[5]  = '{19'd99,     24'h000099, 3'd2};
        vecs[6]  = '{19'd100,    24'h000100, 3'd3};
        vecs[7]  = '{19'd12345,  24'h012345, 3'd5};
        vecs[8]  = '{19'd99999,  24'h099999, 3'd5};
        vecs[9]  = '{19'd100000, 24'h100000, 3'd6};
        vecs[10] = '{19'd500000, 24'h500000, 3'd6};
        vecs[11] = '{19'd65535,  24'h065535, 3'd5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_bcd", out_bcd, 0);
        check("reset out_ndig", out_ndig, 1);

        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i].bin, vecs[i].bcd, int'(vecs[i].ndig), 1'b0, $sformatf("vec%0d", i));
        end

        // Hold result with out_ready low for 10 cycles.
        in_valid = 1'b1;
        in_bin   = 19'd1000;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("hold busy during convert", busy, 1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check("hold out_valid", out_valid, 1);
            check("hold bcd", out_bcd, 24'h001000);
            check("hold ndig", out_ndig, 4);
            check("hold in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold release in_ready", in_ready, 1);
        check("hold release out_valid", out_valid, 0);

        // Reset in cycle 7 of CONVERT discards the word.
        in_valid = 1'b1;
        in_bin   = 19'd12345;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        check("mid reset busy before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset in_ready", in_ready, 1);
        check("mid reset out_valid", out_valid, 0);
        check("mid reset busy", busy, 0);
        for (int i = 0; i < 25; i++) begin
            check("mid reset no output", out_valid, 0);
            tick();
        end
        run_one(19'd99, 24'h000099, 2, 1'b0, "after reset");

        // Input noise while busy is ignored; exactly one result.
        run_one(19'd314159, ref_bcd(314159), ref_ndig(314159), 1'b1, "noisy");
        for (int i = 0; i < 5; i++) begin
            check("noisy single result", out_valid, 0);
            tick();
        end

        // Randomized back-to-back traffic against the decimal model.
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 80000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_bin    = W'($urandom);
            if ($urandom_range(0, 15) == 0) in_bin = '1;
            if ($urandom_range(0, 15) == 0) in_bin = '0;
            out_ready = 1'($urandom_range(0, 1));
            check("rand valid/ready overlap", out_valid && in_ready, 0);
            if (in_valid && in_ready) exp_q.push_back(int'(in_bin));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand spurious result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand bcd", out_bcd, ref_bcd(e));
                    check("rand ndig", out_ndig, ref_ndig(e));
                end
                got++;
            end
            tick();
            cyc++;
        end
        check("rand result count", got, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_seq_converter.md
BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter W, default 19: width of the unsigned binary input.
REQ-002 Parameter DIGITS, default 6: number of BCD output digits; legal only if 10^DIGITS > 2^W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  converter can accept a word.
REQ-007 in_bin  input  W  unsigned binary value; sampled only on input handshake.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_bcd  output  4*DIGITS  packed BCD result; digit k at bits [4k+3:4k], digit 0 least significant.
REQ-011 out_ndig  output  $clog2(DIGITS+1)  count of significant digits, leading zeros excluded, minimum 1.
REQ-012 busy  output  1  high in CONVERT and DONE states.

Function
REQ-013 FSM states SHALL be IDLE, CONVERT and DONE only; any other encoding SHALL return to IDLE on the next edge.
REQ-014 in_ready SHALL equal 1 in IDLE and 0 in CONVERT and DONE; there is no overlap of input acceptance with a pending result.
REQ-015 IDLE with in_valid=1: capture in_bin into a W-bit shift register, clear the 4*DIGITS accumulator, clear the step counter, and go to CONVERT.
REQ-016 IDLE with in_valid=0: stay in IDLE; all registers hold.
REQ-017 CONVERT step, every cycle: each accumulator digit >4 gets +3 (4-bit, no carry out of the digit), then {accumulator, shift register} shifts left 1 and the shift-register MSB enters accumulator bit 0.
REQ-018 The step counter SHALL increment per CONVERT cycle; after exactly W steps the state SHALL go to DONE.
REQ-019 Latency: if the handshake occurs in cycle 0, out_valid SHALL first be 1 in cycle W+1; throughput is one word per W+2 cycles with out_ready held at 1.
REQ-020 DONE: out_valid=1; out_bcd and out_ndig SHALL stay stable until the output handshake.
REQ-021 DONE with out_ready=1: go to IDLE; out_valid SHALL be 0 in the next cycle.
REQ-022 DONE with out_ready=0: hold DONE indefinitely, with no change to any output.
REQ-023 out_valid SHALL be 0 in IDLE and CONVERT; out_bcd content outside DONE is don't-care for checking.
REQ-024 out_ndig SHALL be the index of the highest nonzero digit +1, or 1 if all digits are zero; it is computed from the registered accumulator.
REQ-025 in_valid and in_bin changes during CONVERT or DONE SHALL have no effect.
REQ-026 Digits above the width needed for 2^W-1 SHALL always read 0.

Reset
REQ-027 With rst=1 at a rising edge: state=IDLE, shift register=0, accumulator=0, counter=0.
REQ-028 After reset: in_ready=1, out_valid=0, busy=0, out_bcd=0, out_ndig=1.
REQ-029 Reset SHALL take priority over all handshakes, including during CONVERT or DONE; the in-flight word is discarded with no output produced.

Verification
REQ-030 in_bin=0 accepted at cycle 0 -> out_valid rises in cycle 20, out_bcd=0x000000, out_ndig=1.
REQ-031 in_bin=524287 -> out_bcd=0x524287, out_ndig=6, out_valid in cycle W+1=20.
REQ-032 in_bin=1000, out_ready=0 for 10 cycles after out_valid -> out_bcd=0x001000 and out_ndig=4 held for all 10 cycles; then out_ready=1 -> next cycle IDLE, in_ready=1.
REQ-033 rst=1 in cycle 7 of CONVERT for in_bin=12345 -> next cycle IDLE, out_valid=0; a new in_bin=99 then yields 0x000099, out_ndig=2.
REQ-034 in_valid held high with in_bin changing every cycle during CONVERT -> result equals the value captured at the handshake; exactly one result per handshake.
REQ-035 Back-to-back 1000 random values with random out_ready -> each out_bcd matches the reference decimal conversion; out_valid never asserts together with in_ready.
